// File: rtl/parity_pkg.sv
// Shared definitions for the windowed parity generator: state encodings and
// the window-length legality test used at elaboration.
`timescale 1ns/1ps
package parity_pkg;

  localparam logic STATE_FILL = 1'b0;
  localparam logic STATE_FULL = 1'b1;

  typedef enum logic {
    ST_FILL = STATE_FILL,
    ST_FULL = STATE_FULL
  } state_t;

  function automatic bit win_legal(input int win);
    return (win >= 2) && (win <= 32);
  endfunction

endpackage

// File: rtl/win_shift_reg.sv
// WIN-bit history shift register with a running parity kept alongside, so the
// window parity is available without a WIN-input XOR tree.
`timescale 1ns/1ps
module win_shift_reg #(
  parameter int WIN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic w,
  input  logic zero_fill,
  input  logic full,
  output logic p_next,
  output logic oldest
);

  logic [WIN-1:0] sr_reg;
  logic [WIN-1:0] sr_next;
  logic           p_reg;

  assign sr_next[0] = w;
  generate
    for (genvar gi = 1; gi < WIN; gi++) begin : g_shift
      assign sr_next[gi] = sr_reg[gi-1];
    end
  endgenerate

  assign oldest = sr_reg[WIN-1];
  // The bit leaving the window only cancels once the window is full.
  assign p_next = p_reg ^ w ^ (full & oldest);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg <= '0;
      p_reg  <= 1'b0;
    end else if (zero_fill) begin
      sr_reg <= '0;
      p_reg  <= 1'b0;
    end else if (shift_en) begin
      sr_reg <= sr_next;
      p_reg  <= p_next;
    end
  end

  assert property (@(posedge clk) disable iff (rst) p_reg == ^sr_reg);

endmodule

// File: rtl/parity_window_gen.sv
// Serial parity generator over a WIN-bit window, sliding or framed, with a
// runtime even/odd sense. A mode change acts as a clear.
`timescale 1ns/1ps
module parity_window_gen
  import parity_pkg::*;
#(
  parameter  int WIN   = 3,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             w,
  input  logic             odd_sel,
  input  logic             blk_mode,
  output logic             z,
  output logic             z_valid,
  output logic [CNT_W-1:0] fill
);

  generate
    if (!win_legal(WIN)) begin : g_bad_win
      $error("parity_window_gen: WIN must be within 2..32");
    end
  endgenerate

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIN - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] fill_reg, fill_next;
  logic             mode_q_reg;
  logic             z_reg, z_next;
  logic             z_valid_reg, z_valid_next;

  logic clear;
  logic accept;
  logic complete;
  logic zero_fill;
  logic p_next;
  logic oldest;

  assign clear     = clr | (blk_mode != mode_q_reg);
  assign accept    = en & ~clear;
  assign complete  = accept & ((state_reg == ST_FULL) | (fill_reg == FILL_LAST));
  // A finished frame in block mode restarts from an empty window.
  assign zero_fill = clear | (complete & mode_q_reg);

  win_shift_reg #(.WIN(WIN)) u_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .w        (w),
    .zero_fill(zero_fill),
    .full     (state_reg == ST_FULL),
    .p_next   (p_next),
    .oldest   (oldest)
  );

  always_comb begin
    state_next   = state_reg;
    fill_next    = fill_reg;
    z_next       = z_reg;
    z_valid_next = 1'b0;
    if (clear) begin
      state_next = ST_FILL;
      fill_next  = '0;
      z_next     = 1'b0;
    end else if (accept) begin
      if (complete) begin
        z_next       = p_next ^ odd_sel;
        z_valid_next = 1'b1;
      end
      if (state_reg == ST_FILL) begin
        if (complete && mode_q_reg) begin
          fill_next = '0;
        end else begin
          fill_next = fill_reg + 1'b1;
          if (complete) state_next = ST_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_FILL;
      fill_reg    <= '0;
      mode_q_reg  <= 1'b0;
      z_reg       <= 1'b0;
      z_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fill_reg    <= fill_next;
      mode_q_reg  <= blk_mode;
      z_reg       <= z_next;
      z_valid_reg <= z_valid_next;
    end
  end

  assign z       = z_reg;
  assign z_valid = z_valid_reg;
  assign fill    = fill_reg;

  // While filling, the top slot has never been written since the last clear.
  assert property (@(posedge clk) disable iff (rst) (state_reg == ST_FILL) |-> !oldest);

endmodule

// File: tb/tb_parity_window_gen.sv
// Scoreboard bench: three instances (WIN=3 sliding, WIN=4 framed odd, WIN=8
// sliding) each checked by their own strobe monitor against queued values.
`timescale 1ns/1ps
module tb_parity_window_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_v[3];
  logic w_v[3];
  logic clr_v[3];
  logic odd_v[3];
  logic blk_v[3];

  logic       z0, zv0, z1, zv1, z2, zv2;
  logic [1:0] fill0;
  logic [2:0] fill1;
  logic [3:0] fill2;

  int total = 0;
  int bad   = 0;

  bit q0[$];
  bit q1[$];
  bit q2[$];

  always #5 clk = ~clk;

  parity_window_gen #(.WIN(3)) dut0 (
    .clk(clk), .rst(rst), .clr(clr_v[0]), .en(en_v[0]), .w(w_v[0]),
    .odd_sel(odd_v[0]), .blk_mode(blk_v[0]), .z(z0), .z_valid(zv0), .fill(fill0));
  parity_window_gen #(.WIN(4)) dut1 (
    .clk(clk), .rst(rst), .clr(clr_v[1]), .en(en_v[1]), .w(w_v[1]),
    .odd_sel(odd_v[1]), .blk_mode(blk_v[1]), .z(z1), .z_valid(zv1), .fill(fill1));
  parity_window_gen #(.WIN(8)) dut2 (
    .clk(clk), .rst(rst), .clr(clr_v[2]), .en(en_v[2]), .w(w_v[2]),
    .odd_sel(odd_v[2]), .blk_mode(blk_v[2]), .z(z2), .z_valid(zv2), .fill(fill2));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fill_of(input int d);
    case (d)
      0:       return int'(fill0);
      1:       return int'(fill1);
      default: return int'(fill2);
    endcase
  endfunction

  function automatic int zv_of(input int d);
    case (d)
      0:       return int'(zv0);
      1:       return int'(zv1);
      default: return int'(zv2);
    endcase
  endfunction

  task automatic step(input int d, input bit e, input bit wb, input bit c);
    for (int i = 0; i < 3; i++) begin
      en_v[i]  = 1'b0;
      w_v[i]   = 1'b0;
      clr_v[i] = 1'b0;
    end
    en_v[d]  = e;
    w_v[d]   = wb;
    clr_v[d] = c;
    @(posedge clk);
    #1;
  endtask

  task automatic bitc(input int d, input bit wb, input int f_exp);
    step(d, 1'b1, wb, 1'b0);
    $display("dut%0d bit w=%0d fill=%0d zv=%0d", d, wb, fill_of(d), zv_of(d));
    chk("fill", fill_of(d), f_exp);
  endtask

  task automatic idlec(input int d, input int f_exp);
    step(d, 1'b0, 1'b1, 1'b0);
    chk("idle_fill", fill_of(d), f_exp);
    chk("idle_zv", zv_of(d), 0);
  endtask

  always @(negedge clk) begin
    if (zv0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL strobe0: unexpected strobe z=%0d", z0);
      end else begin
        bit e;
        e = q0.pop_front();
        $display("dut0 strobe z=%0d expected %0d", z0, e);
        if (z0 !== e) begin
          bad++;
          $display("FAIL z0: got %0d expected %0d", z0, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (zv1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL strobe1: unexpected strobe z=%0d", z1);
      end else begin
        bit e;
        e = q1.pop_front();
        $display("dut1 strobe z=%0d expected %0d", z1, e);
        if (z1 !== e) begin
          bad++;
          $display("FAIL z1: got %0d expected %0d", z1, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (zv2) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL strobe2: unexpected strobe z=%0d", z2);
      end else begin
        bit e;
        e = q2.pop_front();
        if (z2 !== e) begin
          bad++;
          $display("FAIL z2: got %0d expected %0d", z2, e);
        end
      end
    end
  end

  initial begin
    bit s1[6];
    bit s3[8];
    bit [7:0] hist;
    int cnt;
    s1 = '{1, 0, 0, 1, 1, 1};
    s3 = '{1, 1, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      en_v[i] = 0; w_v[i] = 0; clr_v[i] = 0; odd_v[i] = 0; blk_v[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z0", z0, 0);   chk("rst_zv0", zv0, 0);   chk("rst_fill0", fill0, 0);
    chk("rst_z1", z1, 0);   chk("rst_fill1", fill1, 0);
    chk("rst_z2", z2, 0);   chk("rst_fill2", fill2, 0);
    rst = 1'b0;
    odd_v[1] = 1'b1;
    blk_v[1] = 1'b1;
    step(1, 1'b0, 1'b0, 1'b0);

    // 1: WIN=3 sliding even, continuous
    q0.push_back(1); q0.push_back(1); q0.push_back(0); q0.push_back(1);
    for (int i = 0; i < 6; i++) bitc(0, s1[i], (i < 2) ? i + 1 : 3);

    // 2: same stream with idle gaps
    step(0, 1'b0, 1'b0, 1'b1);
    chk("clr_fill", fill0, 0);
    q0.push_back(1); q0.push_back(1); q0.push_back(0); q0.push_back(1);
    for (int i = 0; i < 6; i++) begin
      bitc(0, s1[i], (i < 2) ? i + 1 : 3);
      idlec(0, (i < 2) ? i + 1 : 3);
    end

    // 3: WIN=4 odd block mode
    q1.push_back(0); q1.push_back(1);
    for (int i = 0; i < 8; i++) bitc(1, s3[i], (i % 4 == 3) ? 0 : (i % 4) + 1);

    // 4: clear with a bit presented
    step(0, 1'b0, 1'b0, 1'b1);
    bitc(0, 1, 1);
    bitc(0, 1, 2);
    step(0, 1'b1, 1'b1, 1'b1);
    chk("clr_drop_fill", fill0, 0);
    chk("clr_z", z0, 0);
    chk("clr_zv", zv0, 0);
    q0.push_back(0);
    bitc(0, 0, 1);
    bitc(0, 1, 2);
    bitc(0, 1, 3);

    // 5: mode toggle with fill=2, then async reset in FULL
    step(0, 1'b0, 1'b0, 1'b1);
    bitc(0, 1, 1);
    bitc(0, 0, 2);
    blk_v[0] = 1'b1;
    step(0, 1'b1, 1'b1, 1'b0);
    chk("mode_fill", fill0, 0);
    chk("mode_zv", zv0, 0);
    q0.push_back(1);
    bitc(0, 1, 1);
    bitc(0, 1, 2);
    bitc(0, 1, 0);
    blk_v[0] = 1'b0;
    step(0, 1'b1, 1'b1, 1'b0);
    chk("mode_back_fill", fill0, 0);
    q0.push_back(1); q0.push_back(1);
    bitc(0, 1, 1);
    bitc(0, 0, 2);
    bitc(0, 0, 3);
    bitc(0, 1, 3);
    chk("pre_rst_z", z0, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_z", z0, 0);
    chk("async_zv", zv0, 0);
    chk("async_fill", fill0, 0);
    #1 rst = 1'b0;
    q0.push_back(0);
    bitc(0, 1, 1);
    bitc(0, 1, 2);
    bitc(0, 0, 3);

    // 6: WIN=8 sliding even, random stream against a history model
    hist = '0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      bit e, b;
      e = ($urandom_range(0, 3) != 0);
      b = $urandom_range(0, 1) != 0;
      if (e) begin
        hist = {hist[6:0], b};
        cnt++;
        if (cnt >= 8) q2.push_back(^hist);
      end
      step(2, e, b, 1'b0);
      chk("rnd_fill", fill2, (cnt < 8) ? cnt : 8);
    end

    repeat (3) step(0, 1'b0, 1'b0, 1'b0);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
